// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//
// Purpose:
//   Shared constants and sizing helpers for the synchronous FIFO and for the
//   Forth core's stack buffers. The helpers turn a DEPTH into the pointer
//   width and the occupancy-count width, so every user sizes them the same way.
//
// Contents:
//   FIFO_DEFAULT_WIDTH  default data bits per entry
//   FIFO_DEFAULT_DEPTH  default number of entries (power of two, >= 2)
//   fifo_ptr_w(depth)   pointer width, $clog2(depth)
//   fifo_cnt_w(depth)   count width, $clog2(depth)+1 (holds 0..depth)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DEFAULT_WIDTH = 8;
    localparam int FIFO_DEFAULT_DEPTH = 256;

    // Pointer width. DEPTH is a power of two and at least 2, so the pointer
    // wraps naturally at DEPTH without any explicit modulo logic.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Count width. One extra bit so that count == DEPTH is representable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
//
// Purpose:
//   Simple dual-port RAM for the FIFO storage: one write port and one read
//   port whose output is registered. The array itself has no reset so that
//   synthesis can map it onto block RAM. Only the read output register has
//   a synchronous reset, which block RAM output registers support.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset of the read output register only
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_re     read enable; loads mem[i_raddr] into o_rdata
//   i_raddr  read address
//   o_rdata  registered read data; holds its value while i_re is low
// -----------------------------------------------------------------------------
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH  = FIFO_DEFAULT_DEPTH,
    localparam int PTR_W = fifo_ptr_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port: no reset, contents are undefined until written.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port. The FIFO never reads and writes the same address
    // in one cycle (that would need count == 0 or count == DEPTH, where one of
    // the two is rejected), so read-during-write behaviour does not matter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Purpose:
//   Parametrised synchronous FIFO with level-sensitive push/pop, registered
//   read data, registered full/empty/almost flags, an occupancy count and
//   optional sticky overflow/underflow flags. Used as the buffer between the
//   Forth core's I/O ports, the UART and the instruction prefetch path.
//
// Configuration:
//   SYNC_FIFO_ERR_EN  when defined, o_overflow / o_underflow are sticky error
//                     flags cleared only by reset. When undefined they are
//                     constant 0 and no error registers are built.
//
// Parameters:
//   WIDTH          data bits per entry
//   DEPTH          number of entries, power of two, >= 2
//   AFULL_THRESH   o_almost_full  when count >= AFULL_THRESH
//   AEMPTY_THRESH  o_almost_empty when count <= AEMPTY_THRESH
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset, priority over everything
//   i_en             clock enable; low means no state change, o_valid = 0
//   i_push, i_data   write request and data
//   i_pop            read request
//   o_data, o_valid  read data and its one-cycle valid pulse
//   o_full, o_empty  count == DEPTH / count == 0
//   o_almost_full    count >= AFULL_THRESH
//   o_almost_empty   count <= AEMPTY_THRESH
//   o_count          occupancy 0..DEPTH
//   o_overflow       sticky: push attempted while full
//   o_underflow      sticky: pop attempted while empty
//
// Handshake:
//   i_push / i_pop are level requests sampled on every rising edge with i_en
//   high. A push is accepted when o_full is low and a pop when o_empty is low,
//   both judged on the registered flags before the edge; a refused request is
//   simply dropped (the requester watches the flags). An accepted pop returns
//   its data on o_data with o_valid high for exactly one cycle after the edge.
// -----------------------------------------------------------------------------
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH         = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH         = FIFO_DEFAULT_DEPTH,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4,
    localparam int PTR_W        = fifo_ptr_w(DEPTH),
    localparam int CNT_W        = fifo_cnt_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AFULL  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] C_AEMPTY = CNT_W'(AEMPTY_THRESH);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] P_ONE    = PTR_W'(1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_almost_empty;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CNT_W-1:0] w_count_next;
    logic [WIDTH-1:0] w_rd_data;

    // Acceptance uses the registered flags only, so a pop in the same cycle
    // never frees room for a push at full (and vice versa at empty).
    assign w_push_ok = i_en & i_push & ~r_full;
    assign w_pop_ok  = i_en & i_pop  & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + C_ONE;
            2'b01:   w_count_next = r_count - C_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, count and flags. With i_en low both accept terms are 0, so
    // everything naturally holds and o_valid drops to 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_valid        <= 1'b0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + P_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + P_ONE;
            end
            r_count        <= w_count_next;
            r_valid        <= w_pop_ok;
            r_full         <= (w_count_next == C_DEPTH);
            r_empty        <= (w_count_next == '0);
            r_almost_full  <= (w_count_next >= C_AFULL);
            r_almost_empty <= (w_count_next <= C_AEMPTY);
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_data),
        .i_re    (w_pop_ok),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags: they record refused requests and clear only on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_en & i_push & r_full) begin
                r_overflow <= 1'b1;
            end
            if (i_en & i_pop & r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`else
    assign o_overflow  = 1'b0;
    assign o_underflow = 1'b0;
`endif

    assign o_data         = w_rd_data;
    assign o_valid        = r_valid;
    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
    assign o_count        = r_count;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//
// Bench for sync_fifo with WIDTH=8, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1.
// A queue-based reference model tracks the FIFO contents; every step drives
// one clock edge and then compares all outputs against the model.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;
    localparam int CW = 3;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          push;
    logic          pop;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
    logic          valid;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;
    logic [CW-1:0] count;
    logic          ovf;
    logic          unf;

    always #5 clk = ~clk;

    sync_fifo #(
        .WIDTH         (W),
        .DEPTH         (D),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (en),
        .i_push         (push),
        .i_data         (din),
        .i_pop          (pop),
        .o_data         (dout),
        .o_valid        (valid),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (afull),
        .o_almost_empty (aempty),
        .o_count        (count),
        .o_overflow     (ovf),
        .o_underflow    (unf)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ovf;
    logic         m_unf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies the FIFO rules for one edge using the occupancy before the edge.
    task automatic model_edge(input logic r, input logic e, input logic pu,
                              input logic [W-1:0] d, input logic po);
        int sz;
        sz = exp_q.size();
        if (r) begin
            exp_q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else if (e) begin
`ifdef SYNC_FIFO_ERR_EN
            if (pu && sz == D) m_ovf = 1'b1;
            if (po && sz == 0) m_unf = 1'b1;
`endif
            m_valid = po && (sz > 0);
            if (po && sz > 0) m_data = exp_q.pop_front();
            if (pu && sz < D) exp_q.push_back(d);
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all();
        int sz;
        sz = exp_q.size();
        check("count",  32'(count),  32'(sz));
        check("empty",  32'(empty),  32'(sz == 0));
        check("full",   32'(full),   32'(sz == D));
        check("afull",  32'(afull),  32'(sz >= AF));
        check("aempty", 32'(aempty), 32'(sz <= AE));
        check("valid",  32'(valid),  32'(m_valid));
        check("data",   32'(dout),   32'(m_data));
        check("ovf",    32'(ovf),    32'(m_ovf));
        check("unf",    32'(unf),    32'(m_unf));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic e, input logic pu,
                        input logic [W-1:0] d, input logic po);
        rst  = r;
        en   = e;
        push = pu;
        din  = d;
        pop  = po;
        @(posedge clk);
        model_edge(r, e, pu, d, po);
        #1;
        check_all();
    endtask

    task automatic do_push(input logic [W-1:0] d);
        step(1'b0, 1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic do_pop();
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [W-1:0] held;
        rst = 1'b1; en = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
        m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        // reset state
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);

        // fill and drain
        do_push(8'h11);
        do_push(8'h22);
        check("fd_afull_lo", 32'(afull), 32'd0);
        do_push(8'h33);
        check("fd_afull_at3", 32'(afull), 32'd1);
        check("fd_full_at3", 32'(full), 32'd0);
        do_push(8'h44);
        check("fd_full_at4", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            do_pop();
            check("fd_valid", 32'(valid), 32'd1);
            check("fd_data", 32'(dout), 32'(8'h11 * (i + 1)));
        end
        idle();
        check("fd_valid_end", 32'(valid), 32'd0);
        check("fd_empty_end", 32'(empty), 32'd1);

        // reset mid-stream with count 2, requests present during reset
        do_push(8'h5A);
        do_push(8'h5B);
        do_pop();
        do_push(8'h5C);
        check("rm_count_pre", 32'(count), 32'd2);
        step(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
        check("rm_count", 32'(count), 32'd0);
        check("rm_empty", 32'(empty), 32'd1);
        check("rm_aempty", 32'(aempty), 32'd1);
        check("rm_valid", 32'(valid), 32'd0);
        check("rm_data", 32'(dout), 32'd0);

        // wrap-around
        for (int i = 0; i < 3; i++) do_push(8'(8'h30 + i));
        for (int i = 0; i < 3; i++) do_pop();
        for (int i = 0; i < 4; i++) do_push(8'(8'hA0 + i));
        for (int i = 0; i < 4; i++) begin
            do_pop();
            check("wrap_data", 32'(dout), 32'(8'hA0 + i));
        end

        // full with push + pop in the same cycle
        for (int i = 0; i < 4; i++) do_push(8'(8'hC0 + i));
        step(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
        check("fpp_count", 32'(count), 32'd3);
        check("fpp_data", 32'(dout), 32'hC0);
        for (int i = 1; i < 4; i++) begin
            do_pop();
            check("fpp_rest", 32'(dout), 32'(8'hC0 + i));
        end

        // pop when empty
        do_pop();
        check("pe_valid", 32'(valid), 32'd0);
        check("pe_count", 32'(count), 32'd0);

        // i_en low with count 2
        do_push(8'h61);
        do_push(8'h62);
        do_push(8'h63);
        do_pop();
        held = dout;
        check("en_held_val", 32'(held), 32'h61);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
            check("en_count", 32'(count), 32'd2);
            check("en_valid", 32'(valid), 32'd0);
            check("en_data", 32'(dout), 32'(held));
        end

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo
